// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Parity modes, receiver states, counter sizing.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer word handshake.
// Master is the receiver, slave the consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] dataOUT;
  logic                 validOUT;
  logic                 readyIN;
  logic                 parityErrOUT;
  logic                 frameErrOUT;
  logic                 overrunOUT;
  logic                 breakOUT;

  modport master (
    output dataOUT,
    output validOUT,
    input  readyIN,
    output parityErrOUT,
    output frameErrOUT,
    output overrunOUT,
    output breakOUT
  );

  modport slave (
    input  dataOUT,
    input  validOUT,
    output readyIN,
    input  parityErrOUT,
    input  frameErrOUT,
    input  overrunOUT,
    input  breakOUT
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// Reset value is a parameter (idle-high lines use 1).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clkIN,
  input  logic resetIN,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // shift the raw input through two flops
  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with one-word buffer.
// Flags parity/framing errors, breaks and overruns.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clkIN,
  input  logic           resetIN,
  input  logic           Rx,
  uart_rx_param_if.master rx_bus
);

  import uart_pkg::*;

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DB_M1 = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_M1 = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  localparam bit ODD     = (PARITY == PAR_ODD);

  logic                 line;
  rx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 pbit_q;
  logic                 stop1_q;
  logic                 pe_q;
  logic                 fe_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 pe_out_q;
  logic                 fe_out_q;
  logic                 ovr_q;
  logic                 brk_q;

  logic tick;
  logic par_x;
  logic first_stop;
  logic fe_now;
  logic is_brk;
  logic accept;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clkIN  (clkIN),
    .resetIN(resetIN),
    .d      (Rx),
    .q      (line)
  );

  assign tick       = (cnt_q == LAST);
  assign par_x      = (^sh_q) ^ line;
  assign first_stop = (bit_q == 4'd0) ? line : stop1_q;
  assign fe_now     = fe_q | ~line;
  assign is_brk     = (sh_q == '0) &&
                      (!HAS_PAR || !pbit_q) &&
                      !first_stop;
  assign accept     = valid_q & rx_bus.readyIN;

  // frame FSM plus output buffer and pulses
  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      pbit_q   <= 1'b0;
      stop1_q  <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      pe_out_q <= 1'b0;
      fe_out_q <= 1'b0;
      ovr_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      brk_q <= 1'b0;
      if (accept) valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!line) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            bit_q <= '0;
            pe_q  <= 1'b0;
            fe_q  <= 1'b0;
            state_q <= line ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q <= '0;
            sh_q  <= {line, sh_q[DATA_BITS-1:1]};
            if (bit_q == DB_M1) begin
              bit_q   <= '0;
              state_q <= HAS_PAR ? uart_pkg::PARITY
                                 : STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            cnt_q   <= '0;
            pbit_q  <= line;
            pe_q    <= ODD ? ~par_x : par_x;
            bit_q   <= '0;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            fe_q  <= fe_now;
            if (bit_q == 4'd0) stop1_q <= line;
            if (bit_q == SB_M1) begin
              bit_q <= '0;
              if (is_brk) begin
                brk_q   <= 1'b1;
                state_q <= WAIT_HIGH;
              end else begin
                state_q <= IDLE;
                if (!valid_q || rx_bus.readyIN) begin
                  data_q   <= sh_q;
                  pe_out_q <= HAS_PAR & pe_q;
                  fe_out_q <= fe_now;
                  valid_q  <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_HIGH: begin
          cnt_q <= '0;
          if (line) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_bus.dataOUT      = data_q;
  assign rx_bus.validOUT     = valid_q;
  assign rx_bus.parityErrOUT = pe_out_q;
  assign rx_bus.frameErrOUT  = fe_out_q;
  assign rx_bus.overrunOUT   = ovr_q;
  assign rx_bus.breakOUT     = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1, 8E1 and 8N2 instances.
// Table-driven frames plus directed corner sequences.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rx;

  uart_rx_param_if #(.DATA_BITS(8)) b0 ();
  uart_rx_param_if #(.DATA_BITS(8)) b1 ();
  uart_rx_param_if #(.DATA_BITS(8)) b2 ();

  uart_rx_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) d0 (
    .clkIN(clk), .resetIN(rst),
    .Rx(rx[0]), .rx_bus(b0)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) d1 (
    .clkIN(clk), .resetIN(rst),
    .Rx(rx[1]), .rx_bus(b1)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(2)
  ) d2 (
    .clkIN(clk), .resetIN(rst),
    .Rx(rx[2]), .rx_bus(b2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       pb;
    logic       s2;
    int         gap;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];
  int brk0 = 0, brk1 = 0, brk2 = 0;
  int ovr0 = 0, ovr1 = 0, ovr2 = 0;
  int errs = 0;
  int checks = 0;

  // record accepted words and pulses just after each falling edge
  always begin
    @(negedge clk);
    #1;
    if (b0.validOUT && b0.readyIN)
      q0.push_back({b0.dataOUT, b0.parityErrOUT, b0.frameErrOUT});
    if (b1.validOUT && b1.readyIN)
      q1.push_back({b1.dataOUT, b1.parityErrOUT, b1.frameErrOUT});
    if (b2.validOUT && b2.readyIN)
      q2.push_back({b2.dataOUT, b2.parityErrOUT, b2.frameErrOUT});
    if (b0.breakOUT) brk0++;
    if (b1.breakOUT) brk1++;
    if (b2.breakOUT) brk2++;
    if (b0.overrunOUT) ovr0++;
    if (b1.overrunOUT) ovr1++;
    if (b2.overrunOUT) ovr2++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d,
                      input logic pb, input logic s2,
                      input int gap);
    logic [15:0] f;
    int n;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (idx == 1) begin
      f[n] = pb;
      n++;
    end
    f[n] = 1'b1;
    n++;
    if (idx == 2) begin
      f[n] = s2;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      rx[idx] = f[i];
      repeat (16) @(negedge clk);
    end
    rx[idx] = 1'b1;
    repeat (16 * gap) @(negedge clk);
  endtask

  task automatic pop(input int idx, output rec_t r,
                     output bit ok);
    ok = 1'b0;
    r = '0;
    for (int k = 0; k < 40 && !ok; k++) begin
      case (idx)
        0: if (q0.size() > 0) begin r = q0.pop_front(); ok = 1'b1; end
        1: if (q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; end
        2: if (q2.size() > 0) begin r = q2.pop_front(); ok = 1'b1; end
        default: ;
      endcase
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic expect_word(input string nm, input int idx,
                             input logic [7:0] ed,
                             input logic epe,
                             input logic efe);
    rec_t r;
    bit ok;
    pop(idx, r, ok);
    chk({nm, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({nm, "_data"}, 32'(r.d), 32'(ed));
      chk({nm, "_pe"}, 32'(r.pe), 32'(epe));
      chk({nm, "_fe"}, 32'(r.fe), 32'(efe));
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{0, 8'hFF, 1'b0, 1'b1, 2, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h03, 1'b0, 1'b1, 2, 8'h03, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h03, 1'b1, 1'b1, 2, 8'h03, 1'b1, 1'b0};
    tbl[5] = '{2, 8'h5A, 1'b0, 1'b0, 2, 8'h5A, 1'b0, 1'b1};
    tbl[6] = '{2, 8'h11, 1'b0, 1'b1, 2, 8'h11, 1'b0, 1'b0};

    rst = 1'b1;
    rx = 3'b111;
    b0.readyIN = 1'b1;
    b1.readyIN = 1'b1;
    b2.readyIN = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(b0.validOUT), 32'd0);
    chk("rst_data", 32'(b0.dataOUT), 32'd0);
    chk("rst_pe", 32'(b0.parityErrOUT), 32'd0);
    chk("rst_fe", 32'(b0.frameErrOUT), 32'd0);
    chk("rst_ovr", 32'(b0.overrunOUT), 32'd0);
    chk("rst_brk", 32'(b0.breakOUT), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].idx, tbl[i].d, tbl[i].pb, tbl[i].s2,
           tbl[i].gap);
      expect_word($sformatf("vec%0d", i), tbl[i].idx,
                  tbl[i].ed, tbl[i].epe, tbl[i].efe);
    end
    chk("q0_empty", 32'(q0.size()), 32'd0);

    rx[0] = 1'b0;
    repeat (320) @(negedge clk);
    rx[0] = 1'b1;
    repeat (64) @(negedge clk);
    chk("brk_count", 32'(brk0), 32'd1);
    chk("brk_noword", 32'(q0.size()), 32'd0);
    chk("brk_valid", 32'(b0.validOUT), 32'd0);
    send(0, 8'h42, 1'b0, 1'b1, 2);
    expect_word("after_brk", 0, 8'h42, 1'b0, 1'b0);

    b0.readyIN = 1'b0;
    send(0, 8'h12, 1'b0, 1'b1, 2);
    chk("ovr_none_yet", 32'(ovr0), 32'd0);
    send(0, 8'h34, 1'b0, 1'b1, 2);
    chk("ovr_count", 32'(ovr0), 32'd1);
    chk("ovr_valid", 32'(b0.validOUT), 32'd1);
    chk("ovr_held", 32'(b0.dataOUT), 32'h12);
    fork
      send(0, 8'h56, 1'b0, 1'b1, 2);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        b0.readyIN = 1'b1;
        @(negedge clk);
        chk("cmp_data", 32'(b0.dataOUT), 32'h56);
        chk("cmp_valid", 32'(b0.validOUT), 32'd1);
        chk("cmp_no_ovr", 32'(ovr0), 32'd1);
      end
    join
    expect_word("held12", 0, 8'h12, 1'b0, 1'b0);
    expect_word("then56", 0, 8'h56, 1'b0, 1'b0);

    rx[0] = 1'b0;
    repeat (5) @(negedge clk);
    rx[0] = 1'b1;
    repeat (48) @(negedge clk);
    chk("glitch_noword", 32'(q0.size()), 32'd0);
    chk("glitch_valid", 32'(b0.validOUT), 32'd0);
    chk("glitch_brk", 32'(brk0), 32'd1);

    fork
      send(0, 8'hF8, 1'b0, 1'b1, 2);
      begin
        repeat (72) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    chk("mrst_valid", 32'(b0.validOUT), 32'd0);
    chk("mrst_noword", 32'(q0.size()), 32'd0);
    chk("mrst_data", 32'(b0.dataOUT), 32'd0);
    chk("mrst_ovr", 32'(ovr0), 32'd1);
    send(0, 8'h7E, 1'b0, 1'b1, 2);
    expect_word("after_rst", 0, 8'h7E, 1'b0, 1'b0);

    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    chk("d1_pulses", 32'(brk1 + ovr1), 32'd0);
    chk("d2_pulses", 32'(brk2 + ovr2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
